pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives the enable and flush controls of the PC and the IF/ID, ID/EX and EX/MEM stage registers, and the flush of MEM/WB, which has no enable.
- Resolves load-use hazards and taken-branch redirects.
- Freezes the pipeline while a multi-cycle data-memory access completes.
- Keeps stall and flush performance counters.

---
 rtl/pipeline_hazard_controller.sv | 164 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards, taken-branch redirects and multi-cycle memory
// freezes; keeps saturating stall/flush performance counters.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   id_rs/id_rt/id_uses_rt          source operands of the ID instruction
//   ex_mem_read/ex_write_reg        load destination of the EX instruction
//   branch_taken         EX redirect; mem_req: MEM instruction accesses memory
//   perf_clr             clears both counters
//   pc_en, *_en, *_flush stage register controls; mem_busy: frozen for memory
//   stall_cnt/flush_cnt  cycles with pc_en=0 / number of redirects
module pipeline_hazard_controller #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_reg,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MEM_LATENCY) + 1;
  localparam bit HAS_WAIT = (MEM_LATENCY > 0);
  // Cycles still to freeze after the first one.
  localparam logic [WW-1:0] LOAD =
    WW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic hazard;
  logic freeze;
  logic redir;
  logic ldu;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    freeze  = 1'b0;
    hazard  = ex_mem_read && (ex_write_reg != 5'd0) &&
              ((ex_write_reg == id_rs) ||
               (id_uses_rt && (ex_write_reg == id_rt)));
    unique case (state_q)
      RUN: begin
        if (HAS_WAIT && mem_req) begin
          freeze  = 1'b1;
          wcnt_d  = LOAD;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (wcnt_q != '0) begin
          freeze = 1'b1;
          wcnt_d = wcnt_q - WW'(1);
        end else begin
          // Release: the access is still in EX/MEM, so mem_req is ignored.
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    redir = !freeze && branch_taken;
    // A redirect squashes the ID instruction, so its hazard is moot.
    ldu   = !freeze && !branch_taken && hazard;
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    mem_busy     = 1'b0;
    unique case (1'b1)
      freeze: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
        mem_busy     = 1'b1;
      end
      redir: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      ldu: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      mem_busy     = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (perf_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!pc_en && (stall_q != '1)) begin
        stall_d = stall_q + CNT_W'(1);
      end
      if (redir && (flush_q != '1)) begin
        flush_d = flush_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: randomized scoreboard bench for three
// builds (latency 2/32b, latency 0/8b, latency 3/4b) driven in lockstep.
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_write_reg = '0;
  logic       id_uses_rt = 0, ex_mem_read = 0, branch_taken = 0;
  logic       mem_req = 0, perf_clr = 0;

  logic [7:0]  o0, o1, o2;
  logic [31:0] s0, f0;
  logic [7:0]  s1, f1;
  logic [3:0]  s2, f2;

  pipeline_hazard_controller #(.MEM_LATENCY(2), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .branch_taken(branch_taken),
    .mem_req(mem_req), .perf_clr(perf_clr),
    .pc_en(o0[7]), .if_id_en(o0[6]), .if_id_flush(o0[5]),
    .id_ex_en(o0[4]), .id_ex_flush(o0[3]), .ex_mem_en(o0[2]),
    .mem_wb_flush(o0[1]), .mem_busy(o0[0]),
    .stall_cnt(s0), .flush_cnt(f0));

  pipeline_hazard_controller #(.MEM_LATENCY(0), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .branch_taken(branch_taken),
    .mem_req(mem_req), .perf_clr(perf_clr),
    .pc_en(o1[7]), .if_id_en(o1[6]), .if_id_flush(o1[5]),
    .id_ex_en(o1[4]), .id_ex_flush(o1[3]), .ex_mem_en(o1[2]),
    .mem_wb_flush(o1[1]), .mem_busy(o1[0]),
    .stall_cnt(s1), .flush_cnt(f1));

  pipeline_hazard_controller #(.MEM_LATENCY(3), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .branch_taken(branch_taken),
    .mem_req(mem_req), .perf_clr(perf_clr),
    .pc_en(o2[7]), .if_id_en(o2[6]), .if_id_flush(o2[5]),
    .id_ex_en(o2[4]), .id_ex_flush(o2[3]), .ex_mem_en(o2[2]),
    .mem_wb_flush(o2[1]), .mem_busy(o2[0]),
    .stall_cnt(s2), .flush_cnt(f2));

  typedef struct {
    logic [7:0] o;
    longint     s;
    longint     f;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int n_chk = 0, n_fail = 0, cyc = 0;

  // Reference model: per build, frozen cycles still owed and whether
  // a release cycle is pending; counters as plain integers.
  int     lat[3] = '{2, 0, 3};
  longint mx[3]  = '{64'hFFFF_FFFF, 255, 15};
  int     rem[3] = '{0, 0, 0};
  bit     pend[3] = '{0, 0, 0};
  longint sc[3] = '{0, 0, 0};
  longint fc[3] = '{0, 0, 0};

  localparam logic [7:0] O_RST = 8'b0010_1010;
  localparam logic [7:0] O_FRZ = 8'b0000_0011;
  localparam logic [7:0] O_RED = 8'b1111_1100;
  localparam logic [7:0] O_LDU = 8'b0001_1100;
  localparam logic [7:0] O_DEF = 8'b1101_0100;

  function automatic exp_t model(int k);
    exp_t e;
    bit frz, red, hz;
    e.s = sc[k];
    e.f = fc[k];
    if (reset) begin
      e.o = O_RST;
      rem[k] = 0; pend[k] = 0; sc[k] = 0; fc[k] = 0;
      return e;
    end
    frz = 0;
    if (rem[k] > 0) begin
      frz = 1; rem[k]--;
    end else if (pend[k]) begin
      pend[k] = 0;
    end else if (mem_req && lat[k] > 0) begin
      frz = 1; rem[k] = lat[k] - 1; pend[k] = 1;
    end
    hz = ex_mem_read && ex_write_reg != 0 &&
         (ex_write_reg == id_rs ||
          (id_uses_rt && ex_write_reg == id_rt));
    red = !frz && branch_taken;
    if (frz)     e.o = O_FRZ;
    else if (red) e.o = O_RED;
    else if (hz)  e.o = O_LDU;
    else          e.o = O_DEF;
    if (perf_clr) begin
      sc[k] = 0; fc[k] = 0;
    end else begin
      if (!e.o[7] && sc[k] < mx[k]) sc[k]++;
      if (red && fc[k] < mx[k]) fc[k]++;
    end
    return e;
  endfunction

  task automatic go(input bit r, mr, bt, rd,
                    input int wr, rs, rt, input bit ut, clr);
    @(posedge clk);
    #1;
    reset = r; mem_req = mr; branch_taken = bt;
    ex_mem_read = rd; ex_write_reg = 5'(wr);
    id_rs = 5'(rs); id_rt = 5'(rt);
    id_uses_rt = ut; perf_clr = clr;
    q0.push_back(model(0));
    q1.push_back(model(1));
    q2.push_back(model(2));
    cyc++;
  endtask

  task automatic idle(int n);
    repeat (n) go(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(string nm, exp_t e, logic [7:0] o,
                     longint s, longint f);
    n_chk += 3;
    if (o !== e.o) begin
      n_fail++;
      $display("FAIL %s ctl cyc=%0d got=%b want=%b", nm, cyc, o, e.o);
    end
    if (s !== e.s) begin
      n_fail++;
      $display("FAIL %s stall_cnt cyc=%0d got=%0d want=%0d",
               nm, cyc, s, e.s);
    end
    if (f !== e.f) begin
      n_fail++;
      $display("FAIL %s flush_cnt cyc=%0d got=%0d want=%0d",
               nm, cyc, f, e.f);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) chk("lat2", q0.pop_front(), o0, s0, f0);
    if (q1.size() > 0) chk("lat0", q1.pop_front(), o1, s1, f1);
    if (q2.size() > 0) chk("lat3", q2.pop_front(), o2, s2, f2);
  end

  initial begin
    // reset with events pending
    go(1, 1, 1, 1, 5, 5, 5, 1, 0);
    go(1, 1, 1, 1, 5, 5, 5, 1, 0);
    idle(2);
    // load-use, then x0 destination, then unused rt
    go(0, 0, 0, 1, 5, 5, 0, 0, 0);
    idle(1);
    go(0, 0, 0, 1, 0, 0, 0, 1, 0);
    go(0, 0, 0, 1, 5, 1, 5, 0, 0);
    go(0, 0, 0, 1, 5, 1, 5, 1, 0);
    idle(2);
    // memory wait with mem_req held
    repeat (5) go(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // freeze beats redirect; redirect acted on at release
    repeat (5) go(0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    // redirect beats load-use
    go(0, 0, 1, 1, 7, 7, 0, 0, 0);
    idle(2);
    // reset in the second freeze cycle
    go(0, 1, 0, 0, 0, 0, 0, 0, 0);
    go(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // long stall for saturation, then clear during stall
    repeat (20) go(0, 0, 0, 1, 3, 3, 0, 0, 0);
    go(0, 0, 0, 1, 3, 3, 0, 0, 1);
    go(0, 0, 0, 1, 3, 3, 0, 0, 0);
    idle(2);
    // randomized traffic
    repeat (3000) begin
      go($urandom_range(99) == 0,
         $urandom_range(9) < 3,
         $urandom_range(9) < 2,
         $urandom_range(1) == 1,
         $urandom_range(3), $urandom_range(3), $urandom_range(3),
         $urandom_range(1) == 1,
         $urandom_range(49) == 0);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d want=0",
               q0.size() + q1.size() + q2.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
